// File: rtl/lutram_fifo_pkg.sv
// Shared sizes and RAM32M port split for the LUTRAM FIFO controller.
package lutram_fifo_pkg;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 6;
    localparam int PTR_W = 6;

    // {DOC,DOB,DOA} / {DIC,DIB,DIA} packing of one 6-bit word
    typedef struct packed {
        logic [1:0] c;
        logic [1:0] b;
        logic [1:0] a;
    } ram_word_t;

    function automatic ram_word_t to_ram(input logic [DW-1:0] w);
        ram_word_t r;
        r.a = w[1:0];
        r.b = w[3:2];
        r.c = w[5:4];
        return r;
    endfunction

    function automatic logic [DW-1:0] from_ram(input ram_word_t r);
        return {r.c, r.b, r.a};
    endfunction

endpackage

// File: rtl/lutram_fifo_outreg.sv
// One-entry output register fed from the RAM32M asynchronous read port.
module lutram_fifo_outreg
    import lutram_fifo_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ram_empty,
    input  logic [DW-1:0] ram_do,
    input  logic          m_ready,
    output logic          load,
    output logic          m_valid,
    output logic [DW-1:0] m_data
);

    assign load = !ram_empty && (!m_valid || m_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= ram_do;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lutram_fifo_ctrl.sv
// 32x6 FIFO controller driving an external RAM32M plus a one-word output
// register; owns pointers, S_READY, LEVEL and ALMOST_FULL.
module lutram_fifo_ctrl
    import lutram_fifo_pkg::*;
#(
    parameter int   AFULL_LVL       = 28,
    parameter logic IS_CLK_INVERTED = 1'b0
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          S_VALID,
    output logic          S_READY,
    input  logic [DW-1:0] S_DATA,
    output logic          M_VALID,
    input  logic          M_READY,
    output logic [DW-1:0] M_DATA,
    output logic [5:0]    LEVEL,
    output logic          ALMOST_FULL,
    output logic          RAM_WE,
    output logic [AW-1:0] RAM_WADDR,
    output logic [AW-1:0] RAM_RADDR,
    output logic [DW-1:0] RAM_DI,
    input  logic [DW-1:0] RAM_DO
);

    localparam logic [6:0] AF_LVL = 7'(AFULL_LVL);

    // Same edge as the RAM32M write port
    logic clk_i;
    assign clk_i = CLK ^ IS_CLK_INVERTED;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic             ram_empty, full_nxt;
    logic             push, pop, load;
    logic [5:0]       level_nxt;
    ram_word_t        di_w, do_w;

    assign ram_empty = (wr_ptr == rd_ptr);
    assign push      = S_VALID && S_READY;
    assign pop       = M_VALID && M_READY;

    assign wr_ptr_nxt = wr_ptr + {5'd0, push};
    assign rd_ptr_nxt = rd_ptr + {5'd0, load};
    assign full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0])
                     && (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
    assign level_nxt  = LEVEL + {5'd0, push} - {5'd0, pop};

    assign di_w      = to_ram(S_DATA);
    assign RAM_DI    = from_ram(di_w);
    assign do_w      = to_ram(RAM_DO);
    assign RAM_WE    = push;
    assign RAM_WADDR = wr_ptr[AW-1:0];
    assign RAM_RADDR = rd_ptr[AW-1:0];

    always_ff @(posedge clk_i or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            S_READY     <= 1'b0;
            LEVEL       <= '0;
            ALMOST_FULL <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            S_READY     <= !full_nxt;
            LEVEL       <= level_nxt;
            ALMOST_FULL <= ({1'b0, level_nxt} >= AF_LVL);
        end
    end

    lutram_fifo_outreg u_outreg (
        .clk       (clk_i),
        .rst_n     (RST_N),
        .ram_empty (ram_empty),
        .ram_do    (from_ram(do_w)),
        .m_ready   (M_READY),
        .load      (load),
        .m_valid   (M_VALID),
        .m_data    (M_DATA)
    );

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Directed bench for lutram_fifo_ctrl with a behavioural RAM32M model.
module tb_lutram_fifo_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       S_VALID, S_READY, M_VALID, M_READY;
    logic [5:0] S_DATA, M_DATA, LEVEL, RAM_DI, RAM_DO;
    logic       ALMOST_FULL, RAM_WE;
    logic [4:0] RAM_WADDR, RAM_RADDR;

    int checks = 0;
    int errors = 0;
    logic [5:0] sbq[$];
    logic [5:0] mem[32];

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (RAM_WE) mem[RAM_WADDR] <= RAM_DI;
    assign RAM_DO = mem[RAM_RADDR];

    lutram_fifo_ctrl #(.AFULL_LVL(28), .IS_CLK_INVERTED(1'b0)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
        .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL),
        .RAM_WE(RAM_WE), .RAM_WADDR(RAM_WADDR), .RAM_RADDR(RAM_RADDR),
        .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Settle, record handshakes into the scoreboard, then advance one edge
    task automatic tick();
        logic p, q;
        logic [5:0] d, e;
        #1;
        p = S_VALID && S_READY;
        q = M_VALID && M_READY;
        d = S_DATA;
        if (q) begin
            if (sbq.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("sb_data", M_DATA, e);
            end
        end
        if (p) sbq.push_back(d);
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic       sv;
        logic [5:0] sd;
        logic       mr;
        logic       e_we;
        logic [4:0] e_wa;
        logic       e_sr;
        logic       e_mv;
        logic [5:0] e_md;
        logic [5:0] e_lv;
        logic       e_af;
    } vec_t;

    vec_t vt[8];

    initial begin
        int pops, pushes, ram_cnt;
        for (int i = 0; i < 32; i++) mem[i] = 6'h3F;
        vt[0] = '{1'b1, 6'h2A, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 6'h00, 6'd0, 1'b0};
        vt[1] = '{1'b1, 6'h2A, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 6'h00, 6'd1, 1'b0};
        vt[2] = '{1'b0, 6'h00, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 6'h2A, 6'd1, 1'b0};
        vt[3] = '{1'b0, 6'h00, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 6'h2A, 6'd0, 1'b0};
        vt[4] = '{1'b1, 6'h15, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 6'h2A, 6'd1, 1'b0};
        vt[5] = '{1'b1, 6'h07, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 6'h15, 6'd2, 1'b0};
        vt[6] = '{1'b0, 6'h00, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 6'h07, 6'd1, 1'b0};
        vt[7] = '{1'b0, 6'h00, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 6'h07, 6'd0, 1'b0};

        RST_N = 1'b0; S_VALID = 1'b0; S_DATA = '0; M_READY = 1'b0;
        #12;
        chk("rst_m_valid", M_VALID, 0);
        chk("rst_m_data", M_DATA, 0);
        chk("rst_level", LEVEL, 0);
        chk("rst_afull", ALMOST_FULL, 0);
        chk("rst_s_ready", S_READY, 0);
        @(posedge CLK); #2;
        RST_N = 1'b1;
        #1;
        chk("rel_s_ready", S_READY, 0);

        for (int i = 0; i < 8; i++) begin
            S_VALID = vt[i].sv; S_DATA = vt[i].sd; M_READY = vt[i].mr;
            #1;
            chk($sformatf("v%0d_we", i), RAM_WE, vt[i].e_we);
            chk($sformatf("v%0d_waddr", i), RAM_WADDR, vt[i].e_wa);
            tick();
            chk($sformatf("v%0d_s_ready", i), S_READY, vt[i].e_sr);
            chk($sformatf("v%0d_m_valid", i), M_VALID, vt[i].e_mv);
            chk($sformatf("v%0d_m_data", i), M_DATA, vt[i].e_md);
            chk($sformatf("v%0d_level", i), LEVEL, vt[i].e_lv);
            chk($sformatf("v%0d_afull", i), ALMOST_FULL, vt[i].e_af);
        end

        // Fill to 33 words with the consumer stalled
        for (int i = 0; i < 33; i++) begin
            S_VALID = 1'b1; S_DATA = 6'(i); M_READY = 1'b0;
            #1;
            chk("fill_s_ready", S_READY, 1);
            tick();
            chk("fill_level", LEVEL, i + 1);
            chk("fill_afull", ALMOST_FULL, int'(i + 1 >= 28));
        end
        chk("full_s_ready", S_READY, 0);
        S_DATA = 6'h3F;
        tick();
        chk("full_hold_level", LEVEL, 33);
        chk("full_hold_s_ready", S_READY, 0);
        S_VALID = 1'b0; M_READY = 1'b1;
        for (int j = 0; j < 33; j++) begin
            #1;
            chk("drain_m_valid", M_VALID, 1);
            chk("drain_m_data", M_DATA, j);
            tick();
            if (j == 0) chk("drain_s_ready", S_READY, 1);
        end
        chk("drained_m_valid", M_VALID, 0);
        chk("drained_level", LEVEL, 0);

        // Streaming from empty
        pops = 0;
        for (int i = 0; i < 100; i++) begin
            S_VALID = 1'b1; S_DATA = 6'(i); M_READY = 1'b1;
            #1;
            if (M_VALID) pops++;
            tick();
            if (i >= 1) chk("stream_m_valid", M_VALID, 1);
            chk("stream_level", LEVEL, sbq.size());
        end
        chk("stream_pops", pops, 98);
        S_VALID = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("stream_end_level", LEVEL, 0);
        chk("stream_end_m_valid", M_VALID, 0);

        // Pointer wrap with random throttling
        pops = 0; pushes = 0;
        for (int n = 0; n < 2000 && pops < 70; n++) begin
            S_VALID = (pushes < 70);
            S_DATA = 6'($urandom_range(0, 63));
            M_READY = 1'($urandom_range(0, 1));
            #1;
            ram_cnt = sbq.size() - int'(M_VALID);
            if (RAM_WE && ram_cnt > 0) chk("wrap_addr_ne", int'(RAM_WADDR == RAM_RADDR), 0);
            if (S_VALID && S_READY) pushes++;
            if (M_VALID && M_READY) pops++;
            tick();
            chk("wrap_level", LEVEL, sbq.size());
        end
        chk("wrap_pops_done", pops, 70);
        M_READY = 1'b0;

        // Backpressure hold
        S_VALID = 1'b1; S_DATA = 6'h11;
        tick();
        S_VALID = 1'b0;
        tick();
        chk("bp_m_valid", M_VALID, 1);
        chk("bp_m_data", M_DATA, 6'h11);
        for (int i = 0; i < 10; i++) begin
            S_VALID = 1'b1; S_DATA = 6'(6'h20 + i);
            tick();
            chk("bp_hold_data", M_DATA, 6'h11);
            chk("bp_level", LEVEL, 2 + i);
        end
        tick();
        chk("bp_level12", LEVEL, 12);

        // Asynchronous reset between edges
        S_VALID = 1'b0;
        #3;
        RST_N = 1'b0;
        #1;
        chk("arst_m_valid", M_VALID, 0);
        chk("arst_s_ready", S_READY, 0);
        chk("arst_level", LEVEL, 0);
        sbq.delete();
        #2;
        RST_N = 1'b1;
        S_VALID = 1'b1; S_DATA = 6'h05;
        tick();
        tick();
        S_VALID = 1'b0;
        tick();
        chk("post_rst_m_valid", M_VALID, 1);
        chk("post_rst_m_data", M_DATA, 6'h05);
        chk("post_rst_level", LEVEL, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
